// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU operation encodings, forwarding-select enum
// and the hard-wired zero register number.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1110;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX-stage source register.
// MEM result beats WB data; register zero is never forwarded.
module fwd_unit
    import mips_pkg::*;
#(
    parameter int unsigned bit_size = 32,
    parameter int unsigned reg_aw   = 5
) (
    input  logic [reg_aw-1:0]   i_reg,
    input  logic [bit_size-1:0] i_reg_data,
    input  logic                i_mem_reg_write,
    input  logic [reg_aw-1:0]   i_mem_wr_addr,
    input  logic [bit_size-1:0] i_mem_result,
    input  logic                i_wb_reg_write,
    input  logic [reg_aw-1:0]   i_wb_wr_addr,
    input  logic [bit_size-1:0] i_wb_data,
    output logic [bit_size-1:0] o_data
);

    localparam logic [reg_aw-1:0] ZeroReg = reg_aw'(REG_ZERO);

    fwd_sel_e w_sel;

    always_comb begin
        w_sel = FWD_REG;
        if (i_mem_reg_write && (i_mem_wr_addr != ZeroReg) && (i_mem_wr_addr == i_reg)) begin
            w_sel = FWD_MEM;
        end else if (i_wb_reg_write && (i_wb_wr_addr != ZeroReg) && (i_wb_wr_addr == i_reg)) begin
            w_sel = FWD_WB;
        end
    end

    always_comb begin
        o_data = i_reg_data;
        case (w_sel)
            FWD_MEM: o_data = i_mem_result;
            FWD_WB:  o_data = i_wb_data;
            default: o_data = i_reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// EX_FORWARD_EN enables MEM/WB forwarding; without it the hazard output also flags plain RAW.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned bit_size = 32,
    parameter int unsigned reg_aw   = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic [3:0]          i_id_alu_op,
    input  logic [bit_size-1:0] i_id_rs_data,
    input  logic [bit_size-1:0] i_id_rt_data,
    input  logic [bit_size-1:0] i_id_imm,
    input  logic [4:0]          i_id_shamt,
    input  logic [reg_aw-1:0]   i_id_rs,
    input  logic [reg_aw-1:0]   i_id_rt,
    input  logic [reg_aw-1:0]   i_id_rd,
    input  logic                i_id_alu_src,
    input  logic                i_id_reg_dst,
    input  logic                i_id_reg_write,
    input  logic                i_id_mem_read,
    input  logic                i_id_mem_write,
    input  logic                i_id_mem_to_reg,
    input  logic                i_mem_reg_write,
    input  logic                i_wb_reg_write,
    input  logic [reg_aw-1:0]   i_mem_wr_addr,
    input  logic [reg_aw-1:0]   i_wb_wr_addr,
    input  logic [bit_size-1:0] i_mem_result,
    input  logic [bit_size-1:0] i_wb_data,
    output logic [3:0]          o_alu_op,
    output logic [bit_size-1:0] o_src1,
    output logic [bit_size-1:0] o_src2,
    output logic [bit_size-1:0] o_store_data,
    output logic [4:0]          o_shamt,
    output logic [reg_aw-1:0]   o_ex_wr_addr,
    output logic                o_ex_reg_write,
    output logic                o_ex_mem_read,
    output logic                o_ex_mem_write,
    output logic                o_ex_mem_to_reg,
    output logic                o_load_use_hazard
);

    localparam logic [reg_aw-1:0] ZeroReg = reg_aw'(REG_ZERO);

    logic [3:0]          r_alu_op;
    logic [bit_size-1:0] r_rs_data;
    logic [bit_size-1:0] r_rt_data;
    logic [bit_size-1:0] r_imm;
    logic [4:0]          r_shamt;
    logic [reg_aw-1:0]   r_rs;
    logic [reg_aw-1:0]   r_rt;
    logic [reg_aw-1:0]   r_wr_addr;
    logic                r_alu_src;
    logic                r_reg_write;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_mem_to_reg;

    // Flush clears every field so a bubble carries no stale operands either.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || i_flush) begin
            r_alu_op     <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_shamt      <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_wr_addr    <= '0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!i_stall) begin
            r_alu_op     <= i_id_alu_op;
            r_rs_data    <= i_id_rs_data;
            r_rt_data    <= i_id_rt_data;
            r_imm        <= i_id_imm;
            r_shamt      <= i_id_shamt;
            r_rs         <= i_id_rs;
            r_rt         <= i_id_rt;
            r_wr_addr    <= i_id_reg_dst ? i_id_rd : i_id_rt;
            r_alu_src    <= i_id_alu_src;
            r_reg_write  <= i_id_reg_write;
            r_mem_read   <= i_id_mem_read;
            r_mem_write  <= i_id_mem_write;
            r_mem_to_reg <= i_id_mem_to_reg;
        end
    end

    logic w_fwd_mem_we;
    logic w_fwd_wb_we;
    logic w_ex_raw;
    logic w_mem_raw;
    logic w_hazard;

    assign w_ex_raw  = (r_wr_addr != ZeroReg) &&
                       ((r_wr_addr == i_id_rs) || (r_wr_addr == i_id_rt));
    assign w_mem_raw = i_mem_reg_write && (i_mem_wr_addr != ZeroReg) &&
                       ((i_mem_wr_addr == i_id_rs) || (i_mem_wr_addr == i_id_rt));

`ifdef EX_FORWARD_EN
    assign w_fwd_mem_we = i_mem_reg_write;
    assign w_fwd_wb_we  = i_wb_reg_write;
    assign w_hazard     = r_mem_read && w_ex_raw;

    logic w_unused_raw;
    assign w_unused_raw = w_mem_raw;
`else
    // No bypass network: selectors stay on register data, and any in-flight write stalls.
    assign w_fwd_mem_we = 1'b0;
    assign w_fwd_wb_we  = 1'b0;
    assign w_hazard     = ((r_mem_read || r_reg_write) && w_ex_raw) || w_mem_raw;

    logic w_unused_wb_we;
    assign w_unused_wb_we = i_wb_reg_write;
`endif

    logic [bit_size-1:0] w_fwd_a;
    logic [bit_size-1:0] w_fwd_b;

    fwd_unit #(
        .bit_size (bit_size),
        .reg_aw   (reg_aw)
    ) u_fwd_a (
        .i_reg           (r_rs),
        .i_reg_data      (r_rs_data),
        .i_mem_reg_write (w_fwd_mem_we),
        .i_mem_wr_addr   (i_mem_wr_addr),
        .i_mem_result    (i_mem_result),
        .i_wb_reg_write  (w_fwd_wb_we),
        .i_wb_wr_addr    (i_wb_wr_addr),
        .i_wb_data       (i_wb_data),
        .o_data          (w_fwd_a)
    );

    fwd_unit #(
        .bit_size (bit_size),
        .reg_aw   (reg_aw)
    ) u_fwd_b (
        .i_reg           (r_rt),
        .i_reg_data      (r_rt_data),
        .i_mem_reg_write (w_fwd_mem_we),
        .i_mem_wr_addr   (i_mem_wr_addr),
        .i_mem_result    (i_mem_result),
        .i_wb_reg_write  (w_fwd_wb_we),
        .i_wb_wr_addr    (i_wb_wr_addr),
        .i_wb_data       (i_wb_data),
        .o_data          (w_fwd_b)
    );

    assign o_alu_op          = r_alu_op;
    assign o_src1            = w_fwd_a;
    assign o_store_data      = w_fwd_b;
    assign o_src2            = r_alu_src ? r_imm : w_fwd_b;
    assign o_shamt           = r_shamt;
    assign o_ex_wr_addr      = r_wr_addr;
    assign o_ex_reg_write    = r_reg_write;
    assign o_ex_mem_read     = r_mem_read;
    assign o_ex_mem_write    = r_mem_write;
    assign o_ex_mem_to_reg   = r_mem_to_reg;
    assign o_load_use_hazard = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding checks follow EX_FORWARD_EN.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [3:0]  id_alu_op;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_wr_addr, wb_wr_addr;
    logic [31:0] mem_result, wb_data;
    logic [3:0]  alu_op;
    logic [31:0] src1, src2, store_data;
    logic [4:0]  shamt, ex_wr_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.bit_size(32), .reg_aw(5)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_id_alu_op       (id_alu_op),
        .i_id_rs_data      (id_rs_data),
        .i_id_rt_data      (id_rt_data),
        .i_id_imm          (id_imm),
        .i_id_shamt        (id_shamt),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_rd           (id_rd),
        .i_id_alu_src      (id_alu_src),
        .i_id_reg_dst      (id_reg_dst),
        .i_id_reg_write    (id_reg_write),
        .i_id_mem_read     (id_mem_read),
        .i_id_mem_write    (id_mem_write),
        .i_id_mem_to_reg   (id_mem_to_reg),
        .i_mem_reg_write   (mem_reg_write),
        .i_wb_reg_write    (wb_reg_write),
        .i_mem_wr_addr     (mem_wr_addr),
        .i_wb_wr_addr      (wb_wr_addr),
        .i_mem_result      (mem_result),
        .i_wb_data         (wb_data),
        .o_alu_op          (alu_op),
        .o_src1            (src1),
        .o_src2            (src2),
        .o_store_data      (store_data),
        .o_shamt           (shamt),
        .o_ex_wr_addr      (ex_wr_addr),
        .o_ex_reg_write    (ex_reg_write),
        .o_ex_mem_read     (ex_mem_read),
        .o_ex_mem_write    (ex_mem_write),
        .o_ex_mem_to_reg   (ex_mem_to_reg),
        .o_load_use_hazard (load_use_hazard)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0;
        id_alu_op = ALU_AND; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        mem_reg_write = 0; wb_reg_write = 0; mem_wr_addr = 0; wb_wr_addr = 0;
        mem_result = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        repeat (2) tick();
        checks++;
        if ({alu_op, src1, src2, store_data, shamt, ex_wr_addr, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_mem_to_reg} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got alu_op=%b src1=%h wr=%0d rw=%b want all zero",
                     alu_op, src1, ex_wr_addr, ex_reg_write);
        end
        @(negedge clk);
        rst = 0;
        id_alu_op = ALU_ADD; id_rs = 8; id_rs_data = 32'h33; id_reg_write = 1;
        id_reg_dst = 1; id_rd = 5;
        tick();
        checks++;
        if (alu_op !== ALU_ADD) begin
            errors++;
            $display("FAIL reset_first_load alu_op got %b want %b", alu_op, ALU_ADD);
        end
        checks++;
        if (ex_wr_addr !== 5'd5) begin
            errors++;
            $display("FAIL reset_first_load ex_wr_addr got %0d want 5", ex_wr_addr);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (alu_op !== 4'b0000 || src1 !== 32'h0 || ex_reg_write !== 1'b0 || ex_wr_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_async got alu_op=%b src1=%h rw=%b wr=%0d want zeros",
                     alu_op, src1, ex_reg_write, ex_wr_addr);
        end
        @(negedge clk);
        rst = 0;
        tick();
        checks++;
        if (alu_op !== ALU_ADD || src1 !== 32'h33 || ex_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_reload got alu_op=%b src1=%h rw=%b want 0010 33 1",
                     alu_op, src1, ex_reg_write);
        end
    endtask

    task automatic test_load_path();
        clear_inputs();
        id_alu_op = ALU_OR; id_rs = 1; id_rt = 2; id_rs_data = 5; id_rt_data = 7;
        id_shamt = 5'd17; id_reg_dst = 0; id_rd = 3;
        tick();
        checks++;
        if (src1 !== 32'd5 || src2 !== 32'd7 || store_data !== 32'd7) begin
            errors++;
            $display("FAIL load_regs got src1=%h src2=%h sd=%h want 5 7 7", src1, src2, store_data);
        end
        checks++;
        if (shamt !== 5'd17 || ex_wr_addr !== 5'd2 || alu_op !== ALU_OR) begin
            errors++;
            $display("FAIL load_fields got shamt=%0d wr=%0d op=%b want 17 2 0001",
                     shamt, ex_wr_addr, alu_op);
        end
        id_alu_src = 1; id_imm = 32'hFFFF_FFFF; id_reg_dst = 1;
        tick();
        checks++;
        if (src2 !== 32'hFFFF_FFFF || store_data !== 32'd7) begin
            errors++;
            $display("FAIL load_imm got src2=%h sd=%h want ffffffff 7", src2, store_data);
        end
        checks++;
        if (ex_wr_addr !== 5'd3) begin
            errors++;
            $display("FAIL load_regdst got wr=%0d want 3", ex_wr_addr);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        id_rs = 9; id_rs_data = 32'hAA; id_rt = 10; id_rt_data = 32'hBB;
        tick();
        mem_reg_write = 1; mem_wr_addr = 9; mem_result = 32'h11;
        wb_reg_write = 1; wb_wr_addr = 9; wb_data = 32'h22;
        #1;
`ifdef EX_FORWARD_EN
        checks++;
        if (src1 !== 32'h11) begin
            errors++;
            $display("FAIL fwd_mem_priority src1 got %h want 11", src1);
        end
        mem_reg_write = 0;
        #1;
        checks++;
        if (src1 !== 32'h22) begin
            errors++;
            $display("FAIL fwd_wb src1 got %h want 22", src1);
        end
        wb_wr_addr = 10;
        #1;
        checks++;
        if (src1 !== 32'hAA || store_data !== 32'h22 || src2 !== 32'h22) begin
            errors++;
            $display("FAIL fwd_rt got src1=%h sd=%h src2=%h want aa 22 22", src1, store_data, src2);
        end
        // register 0 must never be bypassed
        mem_reg_write = 1; mem_wr_addr = 0; wb_wr_addr = 0;
        id_rs = 0; id_rs_data = 32'h5;
        tick();
        checks++;
        if (src1 !== 32'h5) begin
            errors++;
            $display("FAIL fwd_reg0 src1 got %h want 5", src1);
        end
`else
        checks++;
        if (src1 !== 32'hAA || store_data !== 32'hBB) begin
            errors++;
            $display("FAIL nofwd_src got src1=%h sd=%h want aa bb", src1, store_data);
        end
        mem_wr_addr = 10; wb_wr_addr = 10;
        #1;
        checks++;
        if (src2 !== 32'hBB) begin
            errors++;
            $display("FAIL nofwd_src2 got %h want bb", src2);
        end
`endif
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_rt = 4; id_reg_dst = 0;
        tick();
        id_mem_read = 0; id_reg_write = 0; id_mem_to_reg = 0;
        id_rs = 7; id_rt = 4;
        #1;
        checks++;
        if (load_use_hazard !== 1'b1 || ex_mem_read !== 1'b1 || ex_mem_to_reg !== 1'b1) begin
            errors++;
            $display("FAIL load_use_hit got hz=%b mr=%b m2r=%b want 1 1 1",
                     load_use_hazard, ex_mem_read, ex_mem_to_reg);
        end
        id_rt = 5;
        #1;
        checks++;
        if (load_use_hazard !== 1'b0) begin
            errors++;
            $display("FAIL load_use_miss got %b want 0", load_use_hazard);
        end
        id_mem_read = 1; id_rt = 0; id_rs = 0;
        tick();
        checks++;
        if (load_use_hazard !== 1'b0 || ex_wr_addr !== 5'd0) begin
            errors++;
            $display("FAIL load_use_reg0 got hz=%b wr=%0d want 0 0", load_use_hazard, ex_wr_addr);
        end
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_alu_op = ALU_SUB; id_rs_data = 32'h100; id_reg_write = 1; id_reg_dst = 1; id_rd = 6;
        id_mem_write = 1;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_alu_op = ALU_ADD; id_rs_data = 32'h200 + i; id_rd = 5'(i + 11); id_reg_write = 0;
            tick();
            checks++;
            if (alu_op !== ALU_SUB || src1 !== 32'h100 || ex_wr_addr !== 5'd6) begin
                errors++;
                $display("FAIL stall_hold[%0d] got op=%b src1=%h wr=%0d want 0110 100 6",
                         i, alu_op, src1, ex_wr_addr);
            end
        end
        flush = 1;
        tick();
        checks++;
        if (ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_wr_addr !== 5'd0) begin
            errors++;
            $display("FAIL flush_over_stall got rw=%b mw=%b wr=%0d want 0 0 0",
                     ex_reg_write, ex_mem_write, ex_wr_addr);
        end
        stall = 0; flush = 0;
    endtask

`ifndef EX_FORWARD_EN
    task automatic test_no_fwd_hazard();
        clear_inputs();
        flush = 1;
        tick();
        flush = 0;
        mem_reg_write = 1; mem_wr_addr = 9; mem_result = 32'h77; id_rs = 9;
        #1;
        checks++;
        if (load_use_hazard !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_mem_raw got %b want 1", load_use_hazard);
        end
        mem_wr_addr = 0; id_rs = 0;
        #1;
        checks++;
        if (load_use_hazard !== 1'b0) begin
            errors++;
            $display("FAIL nofwd_mem_reg0 got %b want 0", load_use_hazard);
        end
        mem_reg_write = 0;
        id_reg_write = 1; id_rt = 12; id_rs_data = 32'h44; id_rs = 3;
        tick();
        id_reg_write = 0; id_rt = 0; id_rs = 12;
        mem_reg_write = 1; mem_wr_addr = 3;
        #1;
        checks++;
        if (load_use_hazard !== 1'b1 || src1 !== 32'h44) begin
            errors++;
            $display("FAIL nofwd_ex_raw got hz=%b src1=%h want 1 44", load_use_hazard, src1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_path();
        test_forwarding();
        test_load_use();
        test_stall_flush();
`ifndef EX_FORWARD_EN
        test_no_fwd_hazard();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
